// File: rtl/mdio_pkg.sv
// Shared definitions for the Clause 45 MDIO responder and its helpers.
//   state_e      : frame decoder states
//   OP_*         : Clause 45 opcode values
//   *_W          : frame field widths
//   BIT_*        : frame bit index of the last bit of each field (ST bit 0 = index 0)
package mdio_pkg;

    typedef enum logic [2:0] {
        StPre,
        StSt,
        StOp,
        StPrtad,
        StDevad,
        StTa,
        StData,
        StSkip
    } state_e;

    localparam logic [1:0] OP_ADDR  = 2'b00;
    localparam logic [1:0] OP_WR    = 2'b01;
    localparam logic [1:0] OP_PRINC = 2'b10;
    localparam logic [1:0] OP_RD    = 2'b11;

    localparam int unsigned OP_W       = 2;
    localparam int unsigned PRTAD_W    = 5;
    localparam int unsigned DEVAD_W    = 5;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned FRAME_BITS = 32;

    localparam logic [4:0] BIT_OP_LAST    = 5'd3;
    localparam logic [4:0] BIT_PRTAD_LAST = 5'd8;
    localparam logic [4:0] BIT_DEVAD_LAST = 5'd13;
    localparam logic [4:0] BIT_TA_LAST    = 5'd15;
    localparam logic [4:0] BIT_FRAME_LAST = 5'd31;

endpackage

// File: rtl/mdio_sync_edge.sv
// Two-flop synchronizers for MDC and MDIO plus MDC edge detection.
//   clk       in   sampling clock
//   reset     in   synchronous, active-high
//   mdc       in   asynchronous management clock
//   mdio_in   in   asynchronous MDIO level
//   mdc_rise  out  one-cycle pulse on a synchronized MDC rising edge
//   mdc_fall  out  one-cycle pulse on a synchronized MDC falling edge
//   mdio_sync out  synchronized MDIO, aligned with the MDC edge pulses
module mdio_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic mdc,
    input  logic mdio_in,
    output logic mdc_rise,
    output logic mdc_fall,
    output logic mdio_sync
);

    logic [1:0] mdc_ff;
    logic       mdc_dly;
    logic [1:0] mdio_ff;

    always_ff @(posedge clk) begin
        if (reset) begin
            mdc_ff  <= 2'b00;
            mdc_dly <= 1'b0;
            mdio_ff <= 2'b11;  // bus idles high through the pull-up
        end else begin
            mdc_ff  <= {mdc_ff[0], mdc};
            mdc_dly <= mdc_ff[1];
            mdio_ff <= {mdio_ff[0], mdio_in};
        end
    end

    assign mdc_rise  = mdc_ff[1] & ~mdc_dly;
    assign mdc_fall  = ~mdc_ff[1] & mdc_dly;
    assign mdio_sync = mdio_ff[1];

endmodule

// File: rtl/mdio_c45_slave.sv
// Clause 45 MDIO responder (PHY side).
//   clk156/reset        clock and synchronous active-high reset
//   mdc, mdio_in        management clock and data from the station manager
//   mdio_out, mdio_tri  MDIO drive value and release (1 = high-Z)
//   prtad               this port's address
//   reg_devad/reg_addr  device and register address of the current access
//   reg_wr/reg_wdata    one-cycle write strobe and data
//   reg_rd/reg_rdata    one-cycle read strobe; data sampled C_RD_LAT cycles later
module mdio_c45_slave
    import mdio_pkg::*;
#(
    parameter logic [31:0] C_DEVAD_MASK = 32'h0000_0002,
    parameter int unsigned C_PRE_MIN    = 32,
    parameter int unsigned C_RD_LAT     = 2
) (
    input  logic               clk156,
    input  logic               reset,
    input  logic               mdc,
    input  logic               mdio_in,
    output logic               mdio_out,
    output logic               mdio_tri,
    input  logic [PRTAD_W-1:0] prtad,
    output logic [DEVAD_W-1:0] reg_devad,
    output logic [DATA_W-1:0]  reg_addr,
    output logic               reg_wr,
    output logic [DATA_W-1:0]  reg_wdata,
    output logic               reg_rd,
    input  logic [DATA_W-1:0]  reg_rdata
);

    localparam int unsigned        PRE_W    = $clog2(C_PRE_MIN + 1);
    localparam logic [PRE_W-1:0]   PRE_SAT  = PRE_W'(C_PRE_MIN);
    // Loaded one above the latency so that the value 1 marks the capture cycle.
    localparam logic [2:0]         LAT_LOAD = 3'(C_RD_LAT + 1);

    logic mdc_rise;
    logic mdc_fall;
    logic mdio_s;

    mdio_sync_edge u_sync (
        .clk      (clk156),
        .reset    (reset),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdc_rise (mdc_rise),
        .mdc_fall (mdc_fall),
        .mdio_sync(mdio_s)
    );

    state_e              state_q;
    logic [PRE_W-1:0]    pre_cnt_q;
    logic [4:0]          bit_cnt_q;   // frame index of the next bit to be sampled
    logic [DATA_W-1:0]   shreg_q;
    logic [1:0]          op_q;
    logic [PRTAD_W-1:0]  prtad_fld_q;
    logic                rd_op_q;
    logic [2:0]          lat_cnt_q;

    logic [DATA_W-1:0]   shift_in;
    logic [DEVAD_W-1:0]  devad_fld;
    logic                dev_match;

    assign shift_in  = {shreg_q[DATA_W-2:0], mdio_s};
    assign devad_fld = shift_in[DEVAD_W-1:0];
    assign dev_match = (prtad_fld_q == prtad) && C_DEVAD_MASK[devad_fld];

    always_ff @(posedge clk156) begin
        if (reset) begin
            state_q     <= StPre;
            pre_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            op_q        <= OP_ADDR;
            prtad_fld_q <= '0;
            rd_op_q     <= 1'b0;
            lat_cnt_q   <= '0;
            mdio_out    <= 1'b1;
            mdio_tri    <= 1'b1;
            reg_devad   <= '0;
            reg_addr    <= '0;
            reg_wr      <= 1'b0;
            reg_wdata   <= '0;
            reg_rd      <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;

            if (lat_cnt_q != 3'd0) begin
                lat_cnt_q <= lat_cnt_q - 3'd1;
                if (lat_cnt_q == 3'd1) begin
                    shreg_q <= reg_rdata;
                end
            end

            if (mdc_rise) begin
                // During TA and read data the register holds outgoing data.
                if (!(state_q == StTa || (state_q == StData && rd_op_q))) begin
                    shreg_q <= shift_in;
                end
                bit_cnt_q <= bit_cnt_q + 5'd1;

                unique case (state_q)
                    StPre: begin
                        bit_cnt_q <= 5'd1;  // a zero here is ST bit 0
                        if (mdio_s) begin
                            if (pre_cnt_q != PRE_SAT) pre_cnt_q <= pre_cnt_q + 1'b1;
                        end else begin
                            pre_cnt_q <= '0;
                            if (pre_cnt_q == PRE_SAT) state_q <= StSt;
                        end
                    end
                    StSt: state_q <= mdio_s ? StSkip : StOp;  // ST=01 is a Clause 22 frame
                    StOp: begin
                        if (bit_cnt_q == BIT_OP_LAST) begin
                            op_q    <= shift_in[1:0];
                            state_q <= StPrtad;
                        end
                    end
                    StPrtad: begin
                        if (bit_cnt_q == BIT_PRTAD_LAST) begin
                            prtad_fld_q <= shift_in[PRTAD_W-1:0];
                            state_q     <= StDevad;
                        end
                    end
                    StDevad: begin
                        if (bit_cnt_q == BIT_DEVAD_LAST) begin
                            if (dev_match) begin
                                reg_devad <= devad_fld;
                                rd_op_q   <= op_q[1];
                                if (op_q[1]) begin
                                    reg_rd    <= 1'b1;
                                    lat_cnt_q <= LAT_LOAD;
                                end
                                state_q <= StTa;
                            end else begin
                                state_q <= StSkip;
                            end
                        end
                    end
                    StTa: begin
                        if (bit_cnt_q == BIT_TA_LAST) state_q <= StData;
                    end
                    StData: begin
                        if (bit_cnt_q == BIT_FRAME_LAST) begin
                            unique case (op_q)
                                OP_ADDR:  reg_addr <= shift_in;
                                OP_WR: begin
                                    reg_wr    <= 1'b1;
                                    reg_wdata <= shift_in;
                                end
                                OP_PRINC: reg_addr <= reg_addr + 16'd1;
                                OP_RD:    ;
                            endcase
                            state_q <= StPre;
                        end
                    end
                    StSkip: begin
                        if (bit_cnt_q == BIT_FRAME_LAST) state_q <= StPre;
                    end
                endcase
            end

            if (mdc_fall) begin
                if (state_q == StTa && rd_op_q && bit_cnt_q == BIT_TA_LAST) begin
                    mdio_tri <= 1'b0;
                    mdio_out <= 1'b0;
                end else if (state_q == StData && rd_op_q) begin
                    mdio_tri <= 1'b0;
                    mdio_out <= shreg_q[DATA_W-1];
                    shreg_q  <= {shreg_q[DATA_W-2:0], 1'b0};
                end else begin
                    mdio_tri <= 1'b1;
                    mdio_out <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_c45_slave.sv
module tb_mdio_c45_slave;

    localparam logic [31:0] DEVAD_MASK = 32'h0000_0002;
    localparam int unsigned PRE_MIN    = 32;
    localparam int          RD_LAT     = 2;

    logic        clk156 = 1'b0;
    logic        reset = 1'b1;
    logic        mdc = 1'b0;
    logic        mdio_in = 1'b1;
    logic [4:0]  prtad = 5'd0;
    logic [15:0] reg_rdata;
    logic        mdio_out, mdio_tri, reg_wr, reg_rd;
    logic [4:0]  reg_devad;
    logic [15:0] reg_addr, reg_wdata;

    always #5 clk156 = ~clk156;

    mdio_c45_slave #(
        .C_DEVAD_MASK(DEVAD_MASK),
        .C_PRE_MIN   (PRE_MIN),
        .C_RD_LAT    (RD_LAT)
    ) dut (
        .clk156   (clk156),
        .reset    (reset),
        .mdc      (mdc),
        .mdio_in  (mdio_in),
        .mdio_out (mdio_out),
        .mdio_tri (mdio_tri),
        .prtad    (prtad),
        .reg_devad(reg_devad),
        .reg_addr (reg_addr),
        .reg_wr   (reg_wr),
        .reg_wdata(reg_wdata),
        .reg_rd   (reg_rd),
        .reg_rdata(reg_rdata)
    );

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // Strobe monitor and register-file responder.
    int          wr_cnt = 0, rd_cnt = 0, tri_low_cnt = 0;
    int          rd_wait = -1;
    logic [15:0] wr_data, wr_addr, rd_addr;
    logic [4:0]  wr_devad;
    logic [15:0] rd_word = 16'h0000;

    always @(negedge clk156) begin
        if (reg_wr) begin
            wr_cnt++;
            wr_data  = reg_wdata;
            wr_addr  = reg_addr;
            wr_devad = reg_devad;
        end
        if (!mdio_tri) tri_low_cnt++;
        if (reg_rd) begin
            rd_cnt++;
            rd_wait = 0;
            rd_addr = reg_addr;
        end else if (rd_wait >= 0 && rd_wait < 100) begin
            rd_wait++;
        end
        // Valid only in the one cycle the core is allowed to sample.
        reg_rdata = (rd_wait == RD_LAT) ? rd_word : ~rd_word;
    end

    // Reference state of the management registers.
    logic [15:0] m_addr = 16'h0000;
    logic [4:0]  m_devad = 5'd0;
    logic        obs_tri[32];
    logic        obs_out[32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b, input int idx);
        mdio_in = b;
        #75;
        if (idx >= 0) begin
            obs_tri[idx] = mdio_tri;
            obs_out[idx] = mdio_out;
        end
        #5 mdc = 1'b1;
        #80 mdc = 1'b0;
    endtask

    task automatic do_frame(input int pre_len, input logic [1:0] st, input logic [1:0] op,
                            input logic [4:0] pa, input logic [4:0] da,
                            input logic [15:0] data, input int abort_at);
        logic [31:0] fr;
        logic [15:0] got;
        logic        tris;
        logic        ok;
        int          wr0, rd0, tl0;
        fr  = {st, op, pa, da, 2'b10, data};
        wr0 = wr_cnt;
        rd0 = rd_cnt;
        tl0 = tri_low_cnt;
        @(negedge clk156);
        #2;
        for (int i = 0; i < pre_len; i++) send_bit(1'b1, -1);
        for (int i = 0; i < 32; i++) begin
            if (i == abort_at) begin
                @(negedge clk156) reset = 1'b1;
                repeat (2) @(negedge clk156);
                check("abort_tri", mdio_tri, 1);
                reset = 1'b0;
                mdio_in = 1'b1;
                repeat (4) @(negedge clk156);
                check("abort_no_wr", wr_cnt - wr0, 0);
                m_addr  = 16'h0000;
                m_devad = 5'd0;
                check("abort_addr", reg_addr, m_addr);
                return;
            end
            // Reads: the manager releases the line from TA onward (pull-up high).
            send_bit((op[1] && i >= 14) ? 1'b1 : fr[31-i], i);
        end
        mdio_in = 1'b1;
        #80;
        repeat (2) @(negedge clk156);

        ok = (pre_len >= PRE_MIN) && (st == 2'b00) && (pa == prtad) && DEVAD_MASK[da];
        check("wr_pulses", wr_cnt - wr0, (ok && op == 2'b01) ? 1 : 0);
        check("rd_pulses", rd_cnt - rd0, (ok && op[1]) ? 1 : 0);
        if (ok) begin
            m_devad = da;
            case (op)
                2'b00: m_addr = data;
                2'b01: begin
                    check("wr_data", wr_data, data);
                    check("wr_addr", wr_addr, m_addr);
                    check("wr_devad", wr_devad, da);
                end
                default: begin
                    check("rd_addr", rd_addr, m_addr);
                    check("ta1_hiz", obs_tri[14], 1);
                    check("ta2_zero", {obs_tri[15], obs_out[15]}, 0);
                    got  = '0;
                    tris = 1'b0;
                    for (int i = 0; i < 16; i++) begin
                        got[15-i] = obs_out[16+i];
                        tris      = tris | obs_tri[16+i];
                    end
                    check("rd_data", got, rd_word);
                    check("rd_driven", tris, 0);
                    if (op == 2'b10) m_addr = m_addr + 16'd1;
                end
            endcase
        end else begin
            check("bus_idle", tri_low_cnt - tl0, 0);
        end
        check("reg_addr", reg_addr, m_addr);
        check("reg_devad", reg_devad, m_devad);
        check("released", mdio_tri, 1);
    endtask

    initial begin
        logic [1:0]  r_op, r_st;
        logic [4:0]  r_pa, r_da;
        logic [15:0] r_data;
        int          r_pl;

        repeat (4) @(negedge clk156);
        check("rst_tri", mdio_tri, 1);
        check("rst_out", mdio_out, 1);
        check("rst_wr", reg_wr, 0);
        check("rst_rd", reg_rd, 0);
        check("rst_addr", reg_addr, 0);
        check("rst_wdata", reg_wdata, 0);
        check("rst_devad", reg_devad, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk156);

        do_frame(32, 2'b00, 2'b00, 5'd0, 5'd1, 16'h0008, -1);
        check("addr_0008", reg_addr, 16'h0008);
        do_frame(32, 2'b00, 2'b01, 5'd0, 5'd1, 16'hA5A5, -1);
        check("wdata_a5a5", reg_wdata, 16'hA5A5);

        rd_word = 16'h1234;
        do_frame(32, 2'b00, 2'b11, 5'd0, 5'd1, 16'h0000, -1);

        do_frame(32, 2'b00, 2'b00, 5'd0, 5'd1, 16'hFFFF, -1);
        rd_word = 16'hBEEF;
        do_frame(32, 2'b00, 2'b10, 5'd0, 5'd1, 16'h0000, -1);
        check("princ_wrap", reg_addr, 16'h0000);

        // Foreign port, disabled device, then a valid frame.
        do_frame(32, 2'b00, 2'b01, 5'd3, 5'd1, 16'h1111, -1);
        rd_word = 16'h4321;
        do_frame(32, 2'b00, 2'b11, 5'd0, 5'd5, 16'h0000, -1);
        do_frame(32, 2'b00, 2'b01, 5'd0, 5'd1, 16'h0F0E, -1);

        // Short preamble (data ends in 0 so no ones carry over), then Clause 22 start.
        do_frame(31, 2'b00, 2'b01, 5'd0, 5'd1, 16'h7770, -1);
        do_frame(32, 2'b01, 2'b01, 5'd0, 5'd1, 16'h3333, -1);

        // Reset at data bit 8 of a write, then a clean write.
        do_frame(32, 2'b00, 2'b01, 5'd0, 5'd1, 16'hC3C3, 24);
        do_frame(32, 2'b00, 2'b01, 5'd0, 5'd1, 16'h5AA5, -1);

        for (int k = 0; k < 14; k++) begin
            r_op   = 2'($urandom);
            r_pa   = ($urandom_range(3) == 0) ? 5'($urandom) : 5'd0;
            r_da   = ($urandom_range(3) == 0) ? 5'($urandom) : 5'd1;
            r_st   = ($urandom_range(7) == 0) ? 2'b01 : 2'b00;
            r_pl   = ($urandom_range(5) == 0) ? 31 : 32 + int'($urandom_range(8));
            r_data = 16'($urandom);
            rd_word = 16'($urandom);
            if (r_pl < 32) begin
                r_op[1]   = 1'b0;
                r_data[0] = 1'b0;
            end
            do_frame(r_pl, r_st, r_op, r_pa, r_da, r_data, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mdio_c45_slave.md
# mdio_c45_slave

Clause 45 MDIO responder for the 10G PHY management path. It sits on the PHY side of the MDC/MDIO link opposite the MAC's MDIO master. It oversamples MDC/MDIO in the clk156 domain, decodes ADDRESS/WRITE/READ/POST-READ-INC frames addressed to this port and an enabled device, and drives a simple single-cycle register-file strobe interface. Read data is shifted back on MDIO with tri-state control.

## Interface
- C_DEVAD_MASK, 32'h0000_0002: bit n set means DEVAD n is served (default: PMA/PMD only).
- C_PRE_MIN, 32: minimum count of consecutive preamble ones before ST is accepted.
- C_RD_LAT, 2: clk156 cycles from reg_rd to valid reg_rdata (range 1..4).

- clk156  in  1  sole clock; MDC must be ≤ clk156/8.
- reset  in  1  synchronous, active-high.
- mdc  in  1  management clock, asynchronous to clk156.
- mdio_in  in  1  MDIO input from pad or master, asynchronous.
- mdio_out  out  1  MDIO drive value.
- mdio_tri  out  1  1 = released (high-Z), 0 = drive mdio_out.
- prtad  in  5  this port's address, quasi-static.
- reg_devad  out  5  DEVAD of the current access.
- reg_addr  out  16  internal address register.
- reg_wr  out  1  one-cycle write strobe.
- reg_wdata  out  16  write data, valid with reg_wr.
- reg_rd  out  1  one-cycle read strobe.
- reg_rdata  in  16  read data, sampled exactly C_RD_LAT cycles after reg_rd.

## Operation
- Input conditioning: mdc and mdio_in each pass through a 2-flop synchronizer. A third mdc flop provides edge detection. mdc_rise and mdc_fall are single-cycle pulses.
- Sampling: the sampled bit is the synchronized mdio_in on the mdc_rise cycle.
- Driving: the output changes only on mdc_fall cycles.
- States and transitions:
  - PRE: counts consecutive sampled 1s, saturating at C_PRE_MIN. A 0 with count ≥ C_PRE_MIN enters ST with the first ST bit = 0. A 0 with count < C_PRE_MIN clears the count and stays in PRE.
  - ST: the second bit must be 0 (ST=00, Clause 45). Otherwise (ST=01, Clause 22) the frame is skipped via SKIP.
  - OP (2 bits) → PRTAD (5) → DEVAD (5).
  - After the DEVAD field: match = (PRTAD == prtad) && C_DEVAD_MASK[DEVAD]. No match → SKIP.
  - TA (2 bits): for READ and POST-READ-INC, mdio_tri stays 1 for TA bit 1. On the mdc_fall starting TA bit 2, drive 0.
  - DATA (16 bits, MSB first).
  - SKIP: counts the remaining bits to a 32-bit frame end with mdio_tri=1, then returns to PRE with the preamble count cleared.
- Op actions (OP field):
  - ADDRESS (00): reg_addr ← DATA after bit 16 is sampled.
  - WRITE (01): reg_wr=1, reg_wdata=DATA, using the current reg_addr.
  - READ (11): reg_rd pulses on the cycle after the last DEVAD bit is sampled. reg_rdata is captured into the shift register C_RD_LAT cycles later. Data bits are driven on successive mdc_fall edges. mdio_tri returns to 1 on the mdc_fall after bit 16.
  - POST-READ-INC (10): same as READ, then reg_addr ← reg_addr+1 mod 2^16 after bit 16.
- reg_devad is latched at DEVAD match and holds until the next match.
- After DATA completes, return to PRE with the preamble count cleared.

## Timing
- Reset values: mdio_tri=1, mdio_out=1, reg_wr=0, reg_rd=0, reg_addr=0, reg_wdata=0, reg_devad=0, state=PRE, preamble count=0.
- Sampling latency: an mdc rising pin edge is acted on 3 clk156 cycles later (2 synchronizer stages plus the edge register).
- reg_wr and reg_addr update: asserted on the cycle after the sampled 16th data bit.
- Read capture: C_RD_LAT ≤ 4 guarantees capture well before the first data-bit drive, since an mdc half-period is ≥ 4 clk156 cycles.
- Reset mid-frame: state returns to PRE immediately and the bus is released. A partial write produces no strobe.
- Concurrent frames: none. A frame arriving while in SKIP/DATA is not decoded until a full preamble is seen.
- reg_addr wrap: 16'hFFFF + 1 = 16'h0000.

## Structure
- Package mdio_pkg holds:
  - state enum (PRE, ST, OP, PRTAD, DEVAD, TA, DATA, SKIP);
  - OP constants (OP_ADDR=2'b00, OP_WR=2'b01, OP_PRINC=2'b10, OP_RD=2'b11);
  - field widths.
- Sub-module: mdio_sync_edge, the 2-flop synchronizer plus edge detector for mdc and mdio_in. It is reusable for the master side.
- The remainder is a single FSM with a 5-bit bit counter, a 16-bit shift register and the read-latency counter.

## Test plan
- ADDRESS devad=1 data=16'h0008, then WRITE data=16'hA5A5, prtad=0 → reg_addr=0x0008; one reg_wr pulse with reg_wdata=0xA5A5 and reg_devad=1.
- READ with reg_rdata=16'h1234 → one reg_rd pulse; TA bit 1 high-Z, TA bit 2 = 0; MDIO shows 0001_0010_0011_0100; released after bit 16.
- POST-READ-INC from reg_addr=0xFFFF → data returned for 0xFFFF, then reg_addr=0x0000.
- Frame with prtad=3 (core prtad=0), or devad=5 with the mask bit clear → no strobes, mdio_tri stays 1, the next valid frame is decoded.
- Only 31 preamble ones, or ST=01 → frame ignored, no strobes.
- reset asserted at data bit 8 of a WRITE → no reg_wr; mdio_tri=1; the following full frame is decoded correctly.
